// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
//   state_t : 2-bit responder FSM encoding (IDLE, BUSY, DONE, WAIT_REL)
//   WORD_W  : data word width
//   OP_RD / OP_WR : latched operation encoding
package mem_pkg;

  localparam int WORD_W = 16;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUSY     = 2'b01,
    DONE     = 2'b10,
    WAIT_REL = 2'b11
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage for the memory responder: 2**ADDR_BITS words of WORD_W bits.
// Synchronous write with enable, asynchronous (combinational) read, no reset.
// Ports:
//   clk   in   clock, rising edge
//   we    in   write enable
//   waddr in   write address
//   wdata in   write data
//   raddr in   read address
//   rdata out  read data, combinational from raddr
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WORD_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed 16-bit memory answering the CPU datapath with a 4-phase
// rdM/wrM -> mfc handshake and a programmable access latency.
// Optional build macro: MEM_PROTECT_EN (write-protect words 0..PROT_LIMIT-1).
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset
//   address in   word address (upper bits above ADDR_BITS ignored)
//   datain  in   write data
//   dataout out  read data, updated only on a read commit
//   rdM     in   read request, held until mfc is seen
//   wrM     in   write request, held until mfc is seen (wins over rdM)
//   mfc     out  one-cycle registered completion pulse
//   busy    out  high whenever the FSM is not IDLE
//   fault   out  protected-write indication alongside mfc
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int LATENCY    = 2,
  parameter int PROT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] datain,
  output logic [WORD_W-1:0] dataout,
  input  logic              rdM,
  input  logic              wrM,
  output logic              mfc,
  output logic              busy,
  output logic              fault
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                 state_reg, state_next;
  logic [3:0]             cnt_reg;
  logic [ADDR_BITS-1:0]   addr_reg;
  logic [WORD_W-1:0]      data_reg;
  logic                   op_reg;
  logic [WORD_W-1:0]      dataout_reg;
  logic                   mfc_reg;
  logic                   fault_reg;
  logic [WORD_W-1:0]      rdata;
  logic                   accept;
  logic                   commit;
  logic                   prot_hit;
  logic                   mem_we;

  assign accept = (state_reg == IDLE) && (wrM || rdM);
  // The access happens on the last BUSY edge; a reset before then aborts it.
  assign commit = (state_reg == BUSY) && (cnt_reg == 4'd0);

`ifdef MEM_PROTECT_EN
  assign prot_hit = (op_reg == OP_WR) && (32'(addr_reg) < PROT_LIMIT);
  assign fault    = fault_reg;
`else
  logic unused_prot;
  assign unused_prot = (PROT_LIMIT == 0) ^ fault_reg;
  assign prot_hit    = 1'b0;
  assign fault       = 1'b0;
`endif

  // Upper address bits alias onto the implemented depth.
  logic unused_addr;
  assign unused_addr = ^address;

  assign mem_we = commit && (op_reg == OP_WR) && !prot_hit;

  mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(addr_reg),
    .wdata(data_reg),
    .raddr(addr_reg),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (wrM || rdM) state_next = BUSY;
      BUSY:     if (cnt_reg == 4'd0) state_next = DONE;
      DONE:     state_next = WAIT_REL;
      WAIT_REL: if (!rdM && !wrM) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= 4'd0;
      addr_reg    <= '0;
      data_reg    <= '0;
      op_reg      <= OP_RD;
      dataout_reg <= '0;
      mfc_reg     <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg <= address[ADDR_BITS-1:0];
        data_reg <= datain;
        op_reg   <= wrM ? OP_WR : OP_RD;
        cnt_reg  <= LAT_M1;
      end else if ((state_reg == BUSY) && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (commit && (op_reg == OP_RD)) begin
        dataout_reg <= rdata;
      end
      // Registered so mfc/fault are high exactly while the FSM sits in DONE.
      mfc_reg   <= (state_next == DONE);
      fault_reg <= (state_next == DONE) && prot_hit;
    end
  end

  assign dataout = dataout_reg;
  assign mfc     = mfc_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (ADDR_BITS=8, LATENCY=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [15:0] datain;
  logic [15:0] dataout;
  logic        rdM;
  logic        wrM;
  logic        mfc;
  logic        busy;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_BITS (8),
    .LATENCY   (2),
    .PROT_LIMIT(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .address(address),
    .datain (datain),
    .dataout(dataout),
    .rdM    (rdM),
    .wrM    (wrM),
    .mfc    (mfc),
    .busy   (busy),
    .fault  (fault)
  );

  // Runs one full handshake: request, wait for mfc (bounded), hold one more
  // cycle, release, one more cycle. Reports what was observed; no checking.
  task automatic do_access(input logic is_wr, input logic [15:0] addr,
                           input logic [15:0] data, output int lat,
                           output logic [15:0] dout, output logic flt,
                           output logic mfc_after, output logic busy_hold,
                           output logic busy_rel);
    address = addr;
    datain  = data;
    wrM     = is_wr;
    rdM     = !is_wr;
    lat     = 0;
    dout    = 16'h0;
    flt     = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mfc) begin
        lat  = i;
        dout = dataout;
        flt  = fault;
        break;
      end
    end
    @(negedge clk);
    mfc_after = mfc;
    busy_hold = busy;
    wrM = 1'b0;
    rdM = 1'b0;
    @(negedge clk);
    busy_rel = busy;
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b0; rdM = 1'b0; wrM = 1'b0; address = 16'h0; datain = 16'h0;
    @(negedge clk);
    checks++; if (dataout !== 16'h0000) begin failures++; $display("FAIL reset_dataout got=%h exp=0000", dataout); end
    checks++; if (mfc !== 1'b0) begin failures++; $display("FAIL reset_mfc got=%b exp=0", mfc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mfc || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL idle_quiet got=%0d exp=0", pulses); end
    $display("test_reset: dataout=%h mfc=%b busy=%b", dataout, mfc, busy);
  endtask

  task automatic test_write_read();
    int lat; logic [15:0] d; logic f, ma, bh, br;
    do_access(1'b1, 16'h0025, 16'hBEEF, lat, d, f, ma, bh, br);
    $display("test_write_read: wr 0025 BEEF lat=%0d", lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (ma !== 1'b0) begin failures++; $display("FAIL wr_mfc_width got=%b exp=0", ma); end
    checks++; if (bh !== 1'b1) begin failures++; $display("FAIL wr_wait_rel_busy got=%b exp=1", bh); end
    checks++; if (br !== 1'b0) begin failures++; $display("FAIL wr_release_idle got=%b exp=0", br); end
    checks++; if (f !== 1'b0) begin failures++; $display("FAIL wr_fault got=%b exp=0", f); end
    checks++; if (dataout !== 16'h0000) begin failures++; $display("FAIL wr_dataout_hold got=%h exp=0000", dataout); end
    do_access(1'b0, 16'h0025, 16'h0000, lat, d, f, ma, bh, br);
    $display("test_write_read: rd 0025 -> %h lat=%0d", d, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (d !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h exp=BEEF", d); end
  endtask

  task automatic test_handshake_hold();
    int pulses; int seen; logic busy_ok;
    address = 16'h0025; rdM = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mfc) begin seen = 1; break; end
    end
    checks++; if (seen !== 1) begin failures++; $display("FAIL hold_mfc_seen got=%0d exp=1", seen); end
    pulses = 0; busy_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mfc) pulses++;
      if (!busy) busy_ok = 1'b0;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL hold_extra_mfc got=%0d exp=0", pulses); end
    checks++; if (busy_ok !== 1'b1) begin failures++; $display("FAIL hold_wait_rel got=%b exp=1", busy_ok); end
    rdM = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", busy); end
    $display("test_handshake_hold: extra_pulses=%0d busy_after_release=%b", pulses, busy);
  endtask

  task automatic test_alias();
    int lat; logic [15:0] d; logic f, ma, bh, br;
    do_access(1'b1, 16'h0103, 16'h1234, lat, d, f, ma, bh, br);
    do_access(1'b0, 16'h0003, 16'h0000, lat, d, f, ma, bh, br);
    $display("test_alias: wr 0103 1234, rd 0003 -> %h", d);
    checks++; if (d !== 16'h1234) begin failures++; $display("FAIL alias_data got=%h exp=1234", d); end
  endtask

  task automatic test_capture();
    int lat; logic [15:0] d; logic f, ma, bh, br;
    do_access(1'b1, 16'h0051, 16'hCAFE, lat, d, f, ma, bh, br);
    address = 16'h0050; datain = 16'h1111; wrM = 1'b1;
    @(negedge clk);               // accepted
    address = 16'h0051; datain = 16'h2222;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mfc) break;
    end
    wrM = 1'b0;
    @(negedge clk); @(negedge clk);
    do_access(1'b0, 16'h0050, 16'h0000, lat, d, f, ma, bh, br);
    checks++; if (d !== 16'h1111) begin failures++; $display("FAIL capture_data got=%h exp=1111", d); end
    do_access(1'b0, 16'h0051, 16'h0000, lat, d, f, ma, bh, br);
    checks++; if (d !== 16'hCAFE) begin failures++; $display("FAIL capture_addr got=%h exp=CAFE", d); end
    $display("test_capture: 0050 and 0051 read back after mid-BUSY input change");
  endtask

  task automatic test_drop();
    int seen;
    address = 16'h0025; rdM = 1'b1;
    @(negedge clk);               // accepted, now BUSY
    rdM = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mfc) begin seen = i + 2; break; end
    end
    checks++; if (seen !== 3) begin failures++; $display("FAIL drop_mfc_edge got=%0d exp=3", seen); end
    checks++; if (dataout !== 16'hBEEF) begin failures++; $display("FAIL drop_dataout got=%h exp=BEEF", dataout); end
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", busy); end
    $display("test_drop: mfc at edge %0d, dataout=%h", seen, dataout);
  endtask

  task automatic test_reset_mid_write();
    int lat; int pulses; logic [15:0] d; logic f, ma, bh, br;
    do_access(1'b1, 16'h0040, 16'h0F0F, lat, d, f, ma, bh, br);
    address = 16'h0040; datain = 16'hAAAA; wrM = 1'b1;
    @(negedge clk);               // accepted, in BUSY
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (dataout !== 16'h0000) begin failures++; $display("FAIL rstmid_dataout got=%h exp=0000", dataout); end
    wrM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mfc) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL rstmid_mfc got=%0d exp=0", pulses); end
    do_access(1'b0, 16'h0040, 16'h0000, lat, d, f, ma, bh, br);
    checks++; if (d !== 16'h0F0F) begin failures++; $display("FAIL rstmid_contents got=%h exp=0F0F", d); end
    $display("test_reset_mid_write: rd 0040 -> %h", d);
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] d; logic f, ma, bh, br;
    do_access(1'b1, 16'h0077, 16'h0001, lat, d, f, ma, bh, br);
    do_access(1'b1, 16'h0077, 16'h8002, lat, d, f, ma, bh, br);
    checks++; if (dataout !== 16'h0F0F) begin failures++; $display("FAIL b2b_dataout_hold got=%h exp=0F0F", dataout); end
    do_access(1'b0, 16'h0077, 16'h0000, lat, d, f, ma, bh, br);
    checks++; if (d !== 16'h8002) begin failures++; $display("FAIL b2b_raw got=%h exp=8002", d); end
    // Both requests high: write wins.
    address = 16'h0078; datain = 16'h4321; wrM = 1'b1; rdM = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mfc) break;
    end
    wrM = 1'b0; rdM = 1'b0;
    @(negedge clk); @(negedge clk);
    do_access(1'b0, 16'h0078, 16'h0000, lat, d, f, ma, bh, br);
    checks++; if (d !== 16'h4321) begin failures++; $display("FAIL wr_priority got=%h exp=4321", d); end
    $display("test_back_to_back: rd 0077 -> 8002, rd 0078 -> %h", d);
  endtask

  task automatic test_protect();
    int lat; logic [15:0] d, old; logic f, ma, bh, br;
    do_access(1'b0, 16'h000F, 16'h0000, lat, old, f, ma, bh, br);
    do_access(1'b1, 16'h000F, 16'h5555, lat, d, f, ma, bh, br);
`ifdef MEM_PROTECT_EN
    checks++; if (f !== 1'b1) begin failures++; $display("FAIL prot_fault got=%b exp=1", f); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL prot_fault_clear got=%b exp=0", fault); end
    do_access(1'b0, 16'h000F, 16'h0000, lat, d, f, ma, bh, br);
    checks++; if (d !== old) begin failures++; $display("FAIL prot_unchanged got=%h exp=%h", d, old); end
`else
    checks++; if (f !== 1'b0) begin failures++; $display("FAIL noprot_fault got=%b exp=0", f); end
    do_access(1'b0, 16'h000F, 16'h0000, lat, d, f, ma, bh, br);
    checks++; if (d !== 16'h5555) begin failures++; $display("FAIL noprot_commit got=%h exp=5555", d); end
`endif
    do_access(1'b1, 16'h0010, 16'h6666, lat, d, f, ma, bh, br);
    checks++; if (f !== 1'b0) begin failures++; $display("FAIL prot_edge_fault got=%b exp=0", f); end
    do_access(1'b0, 16'h0010, 16'h0000, lat, d, f, ma, bh, br);
    checks++; if (d !== 16'h6666) begin failures++; $display("FAIL prot_edge_commit got=%h exp=6666", d); end
    $display("test_protect: rd 0010 -> %h", d);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_handshake_hold();
    test_alias();
    test_capture();
    test_drop();
    test_reset_mid_write();
    test_back_to_back();
    test_protect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
